// File: rtl/fifo_sync_param_if.sv
// Bus bundle for fifo_sync_param: request side (cs, wr_en, rd_en, data_in)
// driven by the master, data and status returned by the FIFO (slave).
interface fifo_sync_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              cs;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output cs, wr_en, rd_en, data_in,
        input  data_out, data_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  cs, wr_en, rd_en, data_in,
        output data_out, data_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with parameterised width/depth, almost-full/empty
// thresholds, overflow/underflow pulses and a registered or
// first-word-fall-through read port.
module fifo_sync_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic              clk,
    input logic              rst,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;

    logic              wr_acc;
    logic              rd_acc;
    logic              is_empty;
    logic              is_full;
    logic [DATA_W-1:0] head;

    // Status comes only from the registered count, so no input reaches a flag.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);
    assign head     = mem_q[rd_ptr_q];

    // Accept decisions and next-state for pointers, count, pulses and read port.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;

        // A read is needed to make room when full, so it is decided first.
        rd_acc      = bus.cs & bus.rd_en & ~is_empty;
        wr_acc      = bus.cs & bus.wr_en & (~is_full | rd_acc);

        overflow_d  = bus.cs & bus.wr_en & ~wr_acc;
        underflow_d = bus.cs & bus.rd_en & ~rd_acc;
        dvalid_d    = rd_acc;

        // Power-of-two depth: pointers wrap DEPTH-1 -> 0 by natural overflow.
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = head;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset wins over any simultaneous read or write.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers and count
        // define what is valid, and leaving it unreset keeps it RAM-mappable.
        if (wr_acc && !rst) mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign bus.data_out     = (FWFT != 0) ? head      : dout_q;
    assign bus.data_valid   = (FWFT != 0) ? ~is_empty : dvalid_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: one registered-read and one FWFT
// instance receive identical stimulus; a queue model predicts contents and
// flags, and a negedge monitor checks the read ports of both.
module tb_fifo_sync_param;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int AE     = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
    fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();

    fifo_sync_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    fifo_sync_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    // Reference model: FIFO contents as a plain queue, plus expected pops.
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] last_out;
    logic [DATA_W-1:0] exp_w;
    bit                exp_ovf;
    bit                exp_udf;
    bit                mon_en = 1'b0;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus, applied to both instances, then flag checks.
    task automatic step(input bit r, input bit c, input bit w, input bit rd,
                        input logic [DATA_W-1:0] d);
        int n;
        bit rd_acc, wr_acc;
        logic [5:0] exp_flags;
        rst          = r;
        bus0.cs      = c;  bus1.cs      = c;
        bus0.wr_en   = w;  bus1.wr_en   = w;
        bus0.rd_en   = rd; bus1.rd_en   = rd;
        bus0.data_in = d;  bus1.data_in = d;
        n      = model_q.size();
        rd_acc = c && rd && (n > 0);
        wr_acc = c && w && ((n < DEPTH) || rd_acc);
        @(posedge clk);
        if (r) begin
            model_q.delete();
            sb_q.delete();
            last_out = '0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else begin
            exp_ovf = c && w && !wr_acc;
            exp_udf = c && rd && !rd_acc;
            if (rd_acc) sb_q.push_back(model_q.pop_front());
            if (wr_acc) model_q.push_back(d);
        end
        #1;
        n = model_q.size();
        exp_flags = {n == 0, n == DEPTH, n <= AE, n >= AF, exp_ovf, exp_udf};
        check("flags0", {bus0.empty, bus0.full, bus0.almost_empty, bus0.almost_full,
                         bus0.overflow, bus0.underflow}, exp_flags);
        check("count0", bus0.count, n);
        check("flags1", {bus1.empty, bus1.full, bus1.almost_empty, bus1.almost_full,
                         bus1.overflow, bus1.underflow}, exp_flags);
        check("count1", bus1.count, n);
        mon_en = 1'b1;
    endtask

    // Monitor: registered port pops the scoreboard on data_valid, else must
    // hold; FWFT port must always show the model's head word.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0) begin
                exp_w    = sb_q.pop_front();
                last_out = exp_w;
                check("valid0", bus0.data_valid, 1);
                check("dout0", bus0.data_out, exp_w);
            end else begin
                check("valid0", bus0.data_valid, 0);
                check("hold0", bus0.data_out, last_out);
            end
            if (model_q.size() > 0) begin
                check("valid1", bus1.data_valid, 1);
                check("head1", bus1.data_out, model_q[0]);
            end else begin
                check("valid1", bus1.data_valid, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wr_bias;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Write 1, 10, 100 then read them back.
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 10);
        step(0, 1, 1, 0, 100);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Read while empty, then simultaneous read+write while empty.
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 32'h55);
        step(0, 1, 0, 1, 0);

        // Nine writes into eight slots, then drain (thresholds both ways).
        for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 32'h100 + i);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);

        // Full with continuous read+write for 20 cycles, across pointer wrap.
        for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 32'h200 + i);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 32'h300 + i);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 1, 0);

        // Requests ignored while deselected; contents preserved.
        step(0, 1, 1, 0, 32'h77);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'hDEAD);
        step(0, 1, 0, 1, 0);

        // FWFT head visible with no read, then reset with words stored.
        step(0, 1, 1, 0, 32'hA5);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 32'hB6);
        step(0, 1, 1, 0, 32'hC7);
        step(1, 1, 1, 1, 32'hEE);
        step(0, 0, 0, 0, 0);

        // Randomised traffic with phases biased toward filling or draining.
        wr_bias = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) wr_bias = ~wr_bias;
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 99) < (wr_bias ? 75 : 30)),
                 ($urandom_range(0, 99) < (wr_bias ? 30 : 75)),
                 $urandom);
        end
        for (int i = 0; i < 9; i++) step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
